// File: rtl/nand_bist_ctrl.sv
// Built-in self-test sequencer for a 2-input gate: sweeps {a,b} through 00..11, settles, samples, compares.
// Optional feature macro NAND_BIST_ERRCNT_EN adds a saturating lifetime mismatch counter (err_count).
module nand_bist_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 5,
  parameter int unsigned CNT_W         = 3,
  parameter logic [3:0]  EXPECT        = 4'b0111
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic       gate_y,
  output logic       gate_a,
  output logic       gate_b,
  output logic [1:0] vec_idx,
  output logic       busy,
  output logic       done,
  output logic       pass,
`ifdef NAND_BIST_ERRCNT_EN
  output logic [7:0] err_count,
`endif
  output logic [3:0] fail_mask
);

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             mismatch_c;
  logic [3:0]       mask_upd_c;
  logic [1:0]       vec_nxt_c;

  // Compare result for the vector currently being sampled, folded into the mask.
  always_comb begin
    mismatch_c = (gate_y != EXPECT[vec_idx]);
    mask_upd_c = fail_mask;
    if (mismatch_c) mask_upd_c[vec_idx] = 1'b1;
    vec_nxt_c  = vec_idx + 2'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      gate_a    <= 1'b0;
      gate_b    <= 1'b0;
      vec_idx   <= 2'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail_mask <= 4'd0;
`ifdef NAND_BIST_ERRCNT_EN
      err_count <= 8'd0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !abort) begin
            fail_mask <= 4'd0;
            pass      <= 1'b0;
            vec_idx   <= 2'd0;
            gate_a    <= 1'b0;
            gate_b    <= 1'b0;
            cnt       <= CNT_LOAD;
            busy      <= 1'b1;
            state     <= SETTLE;
          end
        end
        SETTLE: begin
          if (abort) begin
            state   <= IDLE;
            busy    <= 1'b0;
            gate_a  <= 1'b0;
            gate_b  <= 1'b0;
            vec_idx <= 2'd0;
            pass    <= 1'b0;
          end else if (cnt == '0) begin
            state <= SAMPLE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        SAMPLE: begin
          // An abort here discards this cycle's compare entirely.
          if (abort) begin
            state   <= IDLE;
            busy    <= 1'b0;
            gate_a  <= 1'b0;
            gate_b  <= 1'b0;
            vec_idx <= 2'd0;
            pass    <= 1'b0;
          end else begin
            fail_mask <= mask_upd_c;
`ifdef NAND_BIST_ERRCNT_EN
            if (mismatch_c && (err_count != 8'hFF)) err_count <= err_count + 8'd1;
`endif
            if (vec_idx == 2'd3) begin
              state   <= DONE;
              done    <= 1'b1;
              pass    <= (mask_upd_c == 4'd0);
              busy    <= 1'b0;
              gate_a  <= 1'b0;
              gate_b  <= 1'b0;
              vec_idx <= 2'd0;
            end else begin
              vec_idx <= vec_nxt_c;
              gate_a  <= vec_nxt_c[1];
              gate_b  <= vec_nxt_c[0];
              cnt     <= CNT_LOAD;
              state   <= SETTLE;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
